// File: rtl/spill_register.sv
// spill_register: two-entry elastic buffer that registers valid, data and ready on a valid/ready stream
// Ports:
//   clk_i   - clock, all state updates on the rising edge
//   rst_i   - synchronous active-high reset, clears both slots
//   valid_i - upstream payload valid
//   ready_o - upstream may transfer (low only when both slots are full)
//   data_i  - upstream payload of type T
//   valid_o - downstream payload valid
//   ready_i - downstream accepts
//   data_o  - downstream payload of type T
module spill_register #(
    parameter type T = logic
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic valid_i,
    output logic ready_o,
    input  T     data_i,
    output logic valid_o,
    input  logic ready_i,
    output T     data_o
);
    logic a_full, b_full;
    T     a_data, b_data;
    logic a_fill, a_drain, b_fill, b_drain;
    // A always presents its entry downstream while B is empty; an unaccepted
    // entry parks in B so A can keep taking new data without looking at ready_i.
    assign a_fill  = valid_i & ready_o;
    assign a_drain = a_full & ~b_full;
    assign b_fill  = a_drain & ~ready_i;
    assign b_drain = b_full & ready_i;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_full <= 1'b0;
            b_full <= 1'b0;
            a_data <= '0;
            b_data <= '0;
        end else begin
            a_full <= a_fill | (a_full & ~a_drain);
            b_full <= b_fill | (b_full & ~b_drain);
            if (a_fill) a_data <= data_i;
            if (b_fill) b_data <= a_data;
        end
    end
    // B holds the older entry whenever it is occupied.
    assign valid_o = a_full | b_full;
    assign data_o  = b_full ? b_data : a_data;
    assign ready_o = ~(a_full & b_full);
endmodule

// File: tb/tb_spill_register.sv
// tb_spill_register: directed table, isolation sequence and randomized FIFO-model check of spill_register
module tb_spill_register;
    typedef logic [31:0] word_t;
    typedef struct {
        logic  rst, v, r;
        word_t d;
        logic  chk, chk_d, ev, er;
        word_t ed;
    } vec_t;

    logic  clk = 1'b0;
    logic  rst_i = 1'b1, valid_i = 1'b0, ready_i = 1'b0;
    word_t data_i = '0;
    logic  valid_o, ready_o;
    word_t data_o;
    int    checks = 0, failures = 0;
    vec_t  tbl[24];
    word_t q[$];
    word_t cur;
    int    sent, recv, cyc;
    logic  acc, deq;

    spill_register #(.T(word_t)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input word_t got, input word_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic rd, input word_t d);
        @(negedge clk);
        rst_i = r; valid_i = v; ready_i = rd; data_i = d;
        #1;
    endtask

    initial begin
        // reset, streaming 01..08, backpressure A1/A2 with refused A3, reset while full
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 1, 1, 0, 1, 0};
        tbl[2]  = '{0, 1, 1, 1, 1, 1, 0, 1, 0};
        for (int i = 3; i <= 9; i++) tbl[i] = '{0, 1, 1, word_t'(i - 1), 1, 1, 1, 1, word_t'(i - 2)};
        tbl[10] = '{0, 0, 1, 0, 1, 1, 1, 1, 32'h08};
        tbl[11] = '{0, 0, 1, 0, 1, 0, 0, 1, 0};
        tbl[12] = '{0, 1, 0, 32'hA1, 1, 0, 0, 1, 0};
        tbl[13] = '{0, 1, 0, 32'hA2, 1, 1, 1, 1, 32'hA1};
        tbl[14] = '{0, 1, 0, 32'hA3, 1, 1, 1, 0, 32'hA1};
        tbl[15] = '{0, 0, 1, 0, 1, 1, 1, 0, 32'hA1};
        tbl[16] = '{0, 0, 1, 0, 1, 1, 1, 1, 32'hA2};
        tbl[17] = '{0, 0, 0, 0, 1, 0, 0, 1, 0};
        tbl[18] = '{0, 1, 0, 32'hB1, 1, 0, 0, 1, 0};
        tbl[19] = '{0, 1, 0, 32'hB2, 1, 1, 1, 1, 32'hB1};
        tbl[20] = '{0, 1, 0, 32'hB3, 1, 1, 1, 0, 32'hB1};
        tbl[21] = '{1, 1, 1, 32'hB4, 1, 1, 1, 0, 32'hB1};
        tbl[22] = '{0, 0, 1, 0, 1, 1, 0, 1, 0};
        tbl[23] = '{0, 0, 1, 0, 1, 1, 0, 1, 0};
        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].rst, tbl[i].v, tbl[i].r, tbl[i].d);
            if (tbl[i].chk) begin
                chk($sformatf("tbl%0d valid_o", i), word_t'(valid_o), word_t'(tbl[i].ev));
                chk($sformatf("tbl%0d ready_o", i), word_t'(ready_o), word_t'(tbl[i].er));
                if (tbl[i].chk_d) chk($sformatf("tbl%0d data_o", i), data_o, tbl[i].ed);
            end
        end

        // combinational isolation: fill both slots, then toggle inputs mid-cycle
        drive(0, 1, 0, 32'hC1);
        drive(0, 1, 0, 32'hC2);
        drive(0, 0, 1, 0);
        chk("iso ready_o r=1", word_t'(ready_o), 0);
        ready_i = 1'b0; #1;
        chk("iso ready_o r=0", word_t'(ready_o), 0);
        valid_i = 1'b1; #1;
        chk("iso valid_o v=1", word_t'(valid_o), 1);
        valid_i = 1'b0; #1;
        chk("iso valid_o v=0", word_t'(valid_o), 1);
        chk("iso data_o", data_o, 32'hC1);

        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        chk("rst2 valid_o", word_t'(valid_o), 0);
        chk("rst2 ready_o", word_t'(ready_o), 1);
        chk("rst2 data_o", data_o, 0);

        // random traffic against a 2-deep FIFO model with registered outputs
        q.delete();
        sent = 0; recv = 0; cyc = 0;
        cur = $urandom;
        while (recv < 1000 && cyc < 20000) begin
            drive(0, (sent < 1000) && ($urandom_range(0, 3) != 0), $urandom_range(0, 2) != 0,
                  0);
            data_i = valid_i ? cur : $urandom;
            #1;
            chk("rnd valid_o", word_t'(valid_o), word_t'(q.size() > 0));
            chk("rnd ready_o", word_t'(ready_o), word_t'(q.size() < 2));
            if (q.size() > 0) chk("rnd data_o", data_o, q[0]);
            acc = valid_i && q.size() < 2;
            deq = q.size() > 0 && ready_i;
            @(posedge clk);
            if (deq) begin
                void'(q.pop_front());
                recv++;
            end
            if (acc) begin
                q.push_back(cur);
                sent++;
                cur = $urandom;
            end
            cyc++;
        end
        chk("rnd words received", word_t'(recv), 1000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
